cpu_bus_arb: RTL and testbench
==============================

CPU_BUS_ARB -- requirements
Module: cpu_bus_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, the number of CE_R ticks a non-master owner may hold the bus before forced release (8-bit, 1..255).
REQ-002 CLK  input  1  single system clock; all state is clocked on its rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 CE_R  input  1  clock enable; state advances only on CLK edges where CE_R=1.
REQ-005 REQ_N  input  3  active-low bus requests; bit0=master SH2, bit1=slave SH2, bit2=SCU.
REQ-006 BUSY  input  1  high while the current owner has a bus cycle in flight (strobe active or wait asserted).
REQ-007 GNT_N  output  3  active-low grants, same bit mapping as REQ_N; at most one bit low at any time.
REQ-008 OWNER  output  2  encoded current owner: 0=master, 1=slave, 2=SCU, 3=none (handoff).
REQ-009 TIMEOUT  output  1  one-CE_R-tick pulse when a forced release occurs.

Function
REQ-010 The FSM shall have three states: PARK (master owns the bus), HANDOFF (no grant), and GRANT (slave or SCU owns the bus).
REQ-011 In PARK, GNT_N=3'b110 and OWNER=0; the master's REQ_N is ignored, because the bus parks on the master.
REQ-012 In PARK, if REQ_N[1] or REQ_N[2] is low (and not masked) and BUSY=0, the FSM shall go to HANDOFF and latch the winner.
REQ-013 In PARK with BUSY=1, the FSM shall stay in PARK and keep the request pending.
REQ-014 Winner selection:
  - one requester active: that requester wins;
  - slave and SCU in the same tick: the one not in LAST wins;
  - LAST updates to the winner at grant.
REQ-015 HANDOFF shall last exactly one CE_R tick with GNT_N=3'b111 and OWNER=3.
REQ-016 HANDOFF then goes to GRANT(winner), or to PARK if no winner is latched.
REQ-017 In GRANT, only the winner's GNT_N bit is low; OWNER is 1 or 2.
REQ-018 In GRANT, the grant is held while the owner's REQ_N=0 or BUSY=1.
REQ-019 In GRANT, when the owner's REQ_N=1 and BUSY=0:
  - if the other non-master requester is active, go to HANDOFF with that requester latched as winner (back-to-back, without parking on the master);
  - otherwise go to HANDOFF and then PARK.
REQ-020 A request that drops while pending in PARK, before HANDOFF is entered, shall be discarded with no grant.
REQ-021 A requester whose REQ_N rises during HANDOFF shall still be granted for one tick, then released per REQ-019.
REQ-022 GNT_N, OWNER and TIMEOUT shall be registered outputs, with no combinational path from inputs.

Reset
REQ-023 While RST=1, asynchronously:
  - state=PARK, GNT_N=3'b110, OWNER=0, TIMEOUT=0;
  - LAST=SCU, so the slave wins the first tie;
  - hold counter=0, mask bits=0.
REQ-024 RST asserted mid-GRANT shall return the grant to the master immediately, with no HANDOFF tick.

Configuration
REQ-025 Macro BUS_ARB_TIMEOUT_EN: when defined, an 8-bit hold counter shall clear on GRANT entry and increment on each CE_R tick in GRANT.
REQ-026 With BUS_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYC and BUSY=0:
  - go to HANDOFF and pulse TIMEOUT;
  - set the owner's mask bit;
  - a masked requester is ignored until its REQ_N is sampled high, which clears the mask.
REQ-027 With BUS_ARB_TIMEOUT_EN defined and BUSY=1 at the limit, the counter shall saturate and release on the first tick with BUSY=0.
REQ-028 Without BUS_ARB_TIMEOUT_EN, there is no counter and no mask, TIMEOUT is tied to 0, and the grant is held indefinitely.

Verification
REQ-029 Reset release, no requests -> GNT_N=110, OWNER=0 held for 100 ticks.
REQ-030 REQ_N=101 (slave), BUSY=0 -> 1 tick GNT_N=111/OWNER=3, then GNT_N=101/OWNER=1; REQ_N back to 111 -> 1 tick 111, then 110.
REQ-031 REQ_N=001 in the same tick after reset -> slave granted first; keep both, release slave -> SCU granted (GNT_N=011) after a single HANDOFF, without the master parking in between.
REQ-032 BUSY=1 in PARK with the SCU requesting -> GNT_N stays 110 until BUSY falls, then HANDOFF, then 011.
REQ-033 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=4, SCU holds REQ_N low -> after 4 GRANT ticks, TIMEOUT=1 for one tick and GNT_N=111 then 110; the SCU stays ungranted until REQ_N goes 1 then 0.
REQ-034 RST pulsed during a slave GRANT -> GNT_N=110 immediately, asynchronously.

Source files
------------

// File: rtl/cpu_bus_arb.sv
// cpu_bus_arb: arbiter for master SH2, slave SH2 and SCU; the bus parks on the master.
// Define BUS_ARB_TIMEOUT_EN to enable forced release of a non-master owner after TIMEOUT_CYC ticks.

module cpu_bus_arb #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE_R,
  input  logic [2:0] REQ_N,
  input  logic       BUSY,
  output logic [2:0] GNT_N,
  output logic [1:0] OWNER,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {StPark, StHandoff, StGrant} state_e;

  localparam logic [1:0] OwnMaster = 2'd0;
  localparam logic [1:0] OwnSlave  = 2'd1;
  localparam logic [1:0] OwnScu    = 2'd2;
  localparam logic [1:0] OwnNone   = 2'd3;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : gen_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  state_e     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic [1:0] last_q, last_d;
  logic [2:0] gnt_n_q, gnt_n_d;
  logic [1:0] owner_q, owner_d;

  // Index 0 = slave SH2, index 1 = SCU.
  logic [1:0] eff_mask;
  logic [1:0] req_act;
  logic       own_req;
  logic       oth_act;
  logic [1:0] oth_code;
  logic       unused_master_req;

  // The master never needs to ask: the bus parks on it.
  assign unused_master_req = REQ_N[0];

  assign req_act  = ~REQ_N[2:1] & ~eff_mask;
  assign own_req  = (win_q == OwnSlave) ? ~REQ_N[1] : ~REQ_N[2];
  assign oth_act  = (win_q == OwnSlave) ? req_act[1] : req_act[0];
  assign oth_code = (win_q == OwnSlave) ? OwnScu : OwnSlave;

  // On a tie the requester that did not win last time goes first.
  function automatic logic [1:0] pick_winner(input logic [1:0] act, input logic [1:0] last);
    logic [1:0] w;
    case (act)
      2'b01:   w = OwnSlave;
      2'b10:   w = OwnScu;
      2'b11:   w = (last == OwnScu) ? OwnSlave : OwnScu;
      default: w = OwnNone;
    endcase
    return w;
  endfunction

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYC);

  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] mask_q, mask_d;
  logic       timeout_q, timeout_d;
  logic       at_limit;

  // Saturates at the limit so a busy owner is released on its first idle tick.
  assign cnt_inc  = (cnt_q == TimeoutLim) ? cnt_q : cnt_q + 8'd1;
  assign at_limit = (cnt_inc == TimeoutLim);
  assign eff_mask = mask_q;
  assign TIMEOUT  = timeout_q;
`else
  assign eff_mask = 2'b00;
  assign TIMEOUT  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    mask_d    = mask_q & ~REQ_N[2:1];
`endif
    unique case (state_q)
      StPark: begin
        if (|req_act && !BUSY) begin
          state_d = StHandoff;
          win_d   = pick_winner(req_act, last_q);
        end
      end
      StHandoff: begin
        if (win_q != OwnNone) begin
          state_d = StGrant;
          last_d  = win_q;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          state_d = StPark;
        end
      end
      StGrant: begin
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        if (!BUSY && !own_req) begin
          state_d = StHandoff;
          win_d   = oth_act ? oth_code : OwnNone;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (!BUSY && at_limit) begin
          state_d   = StHandoff;
          win_d     = oth_act ? oth_code : OwnNone;
          timeout_d = 1'b1;
          if (win_q == OwnSlave) mask_d[0] = 1'b1;
          else                   mask_d[1] = 1'b1;
        end
`endif
      end
      default: state_d = StPark;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    gnt_n_d = 3'b110;
    owner_d = OwnMaster;
    case (state_d)
      StHandoff: begin
        gnt_n_d = 3'b111;
        owner_d = OwnNone;
      end
      StGrant: begin
        if (win_d == OwnSlave) begin
          gnt_n_d = 3'b101;
          owner_d = OwnSlave;
        end else begin
          gnt_n_d = 3'b011;
          owner_d = OwnScu;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StPark;
      win_q   <= OwnNone;
      last_q  <= OwnScu;
      gnt_n_q <= 3'b110;
      owner_q <= OwnMaster;
    end else if (CE_R) begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_n_q <= gnt_n_d;
      owner_q <= owner_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= 8'd0;
      mask_q    <= 2'b00;
      timeout_q <= 1'b0;
    end else if (CE_R) begin
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign GNT_N = gnt_n_q;
  assign OWNER = owner_q;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Self-checking bench for cpu_bus_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an owner-centric reference model.

module tb_cpu_bus_arb;

  localparam int unsigned TCYC = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE_R = 1'b0;
  logic [2:0] REQ_N = 3'b111;
  logic       BUSY = 1'b0;
  logic [2:0] GNT_N;
  logic [1:0] OWNER;
  logic       TIMEOUT;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  cpu_bus_arb #(
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CE_R   (CE_R),
    .REQ_N  (REQ_N),
    .BUSY   (BUSY),
    .GNT_N  (GNT_N),
    .OWNER  (OWNER),
    .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the bus (0 master, 1 slave, 2 SCU, 3 nobody),
  // who is queued for the next grant, who won last, and how long the owner has held.
  int       m_own  = 0;
  int       m_next = 0;
  int       m_last = 2;
  int       m_hold = 0;
  bit [2:0] m_mask = 3'b000;
  bit       m_to   = 1'b0;

  task automatic m_reset();
    m_own  = 0;
    m_next = 0;
    m_last = 2;
    m_hold = 0;
    m_mask = 3'b000;
    m_to   = 1'b0;
  endtask

  task automatic m_step(input logic [2:0] rq_n, input logic busy);
    bit [2:0] want;
    int       o;
    int       oth;
    bit       rel;
    want = 3'b000;
    for (int i = 1; i < 3; i++) want[i] = !rq_n[i] && !m_mask[i];
    for (int i = 1; i < 3; i++) if (rq_n[i]) m_mask[i] = 1'b0;
    m_to = 1'b0;
    if (m_own == 0) begin
      if ((want[1] || want[2]) && !busy) begin
        if (want[1] && want[2]) m_next = (m_last == 2) ? 1 : 2;
        else                    m_next = want[1] ? 1 : 2;
        m_own = 3;
      end
    end else if (m_own == 3) begin
      if (m_next != 0) begin
        m_own  = m_next;
        m_last = m_next;
        m_hold = 0;
      end else begin
        m_own = 0;
      end
    end else begin
      o   = m_own;
      oth = 3 - o;
      rel = 1'b0;
      if (ToEn) m_hold = (m_hold < int'(TCYC)) ? m_hold + 1 : int'(TCYC);
      if (!busy && rq_n[o]) begin
        rel = 1'b1;
      end else if (ToEn && !busy && m_hold == int'(TCYC)) begin
        rel       = 1'b1;
        m_to      = 1'b1;
        m_mask[o] = 1'b1;
      end
      if (rel) begin
        m_next = want[oth] ? oth : 0;
        m_own  = 3;
      end
    end
  endtask

  function automatic logic [2:0] exp_gnt();
    if (m_own == 3) return 3'b111;
    return 3'b111 & ~(3'b001 << m_own);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m_reset();
    else if (CE_R) m_step(REQ_N, BUSY);
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_gnt_n", int'(GNT_N), int'(exp_gnt()));
      check("model_owner", int'(OWNER), m_own);
      check("model_timeout", int'(TIMEOUT), int'(m_to));
    end
  end

  task automatic tick_exp(input string name, input logic [2:0] g, input logic [1:0] o,
                          input logic t);
    @(posedge CLK);
    @(negedge CLK);
    check({name, "_gnt_n"}, int'(GNT_N), int'(g));
    check({name, "_owner"}, int'(OWNER), int'(o));
    check({name, "_timeout"}, int'(TIMEOUT), int'(t));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST   = 1'b1;
    REQ_N = 3'b111;
    BUSY  = 1'b0;
    CE_R  = 1'b1;
    @(negedge CLK);
    #2;
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge CLK);
    check("rst_gnt_n", int'(GNT_N), 6);
    check("rst_owner", int'(OWNER), 0);
    check("rst_timeout", int'(TIMEOUT), 0);
    #2;
    RST    = 1'b0;
    CE_R   = 1'b1;
    chk_en = 1'b1;

    // Idle after reset: parked on the master.
    bad = 0;
    repeat (100) begin
      @(posedge CLK);
      @(negedge CLK);
      if (GNT_N !== 3'b110 || OWNER !== 2'd0) bad++;
    end
    check("park_100", bad, 0);

    // Single slave request and release.
    REQ_N = 3'b101;
    tick_exp("slv_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("slv_gnt", 3'b101, 2'd1, 1'b0);
    REQ_N = 3'b111;
    tick_exp("slv_rel_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("slv_park", 3'b110, 2'd0, 1'b0);

    // Tie after reset: slave first, then SCU back-to-back.
    do_reset();
    REQ_N = 3'b001;
    tick_exp("tie_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("tie_slv", 3'b101, 2'd1, 1'b0);
    tick_exp("tie_slv_hold", 3'b101, 2'd1, 1'b0);
    REQ_N = 3'b011;
    tick_exp("b2b_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("b2b_scu", 3'b011, 2'd2, 1'b0);
    REQ_N = 3'b111;
    tick_exp("b2b_rel_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("b2b_park", 3'b110, 2'd0, 1'b0);

    // BUSY holds the master in PARK, then holds the SCU grant.
    BUSY  = 1'b1;
    REQ_N = 3'b011;
    repeat (3) tick_exp("busy_park", 3'b110, 2'd0, 1'b0);
    BUSY = 1'b0;
    tick_exp("busy_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("busy_scu", 3'b011, 2'd2, 1'b0);
    BUSY  = 1'b1;
    REQ_N = 3'b111;
    repeat (2) tick_exp("busy_hold", 3'b011, 2'd2, 1'b0);
    BUSY = 1'b0;
    tick_exp("busy_rel_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("busy_rel_park", 3'b110, 2'd0, 1'b0);

    // Asynchronous reset mid-grant.
    REQ_N = 3'b101;
    tick_exp("ar_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("ar_slv", 3'b101, 2'd1, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_gnt_n", int'(GNT_N), 6);
    check("async_rst_owner", int'(OWNER), 0);
    @(negedge CLK);
    #2;
    RST   = 1'b0;
    REQ_N = 3'b111;
    @(negedge CLK);

`ifdef BUS_ARB_TIMEOUT_EN
    // Forced release of a hogging SCU, then masked until it re-requests.
    do_reset();
    REQ_N = 3'b011;
    tick_exp("to_ho", 3'b111, 2'd3, 1'b0);
    repeat (4) tick_exp("to_scu", 3'b011, 2'd2, 1'b0);
    tick_exp("to_pulse", 3'b111, 2'd3, 1'b1);
    tick_exp("to_park", 3'b110, 2'd0, 1'b0);
    repeat (3) tick_exp("to_masked", 3'b110, 2'd0, 1'b0);
    REQ_N = 3'b111;
    tick_exp("to_unmask", 3'b110, 2'd0, 1'b0);
    REQ_N = 3'b011;
    tick_exp("to_re_ho", 3'b111, 2'd3, 1'b0);
    tick_exp("to_re_scu", 3'b011, 2'd2, 1'b0);
    REQ_N = 3'b111;
    tick_exp("to_re_rel", 3'b111, 2'd3, 1'b0);
    tick_exp("to_re_park", 3'b110, 2'd0, 1'b0);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      @(negedge CLK);
      #2;
      if ($urandom_range(3) == 0) REQ_N = 3'($urandom);
      BUSY = ($urandom_range(2) == 0);
      CE_R = ($urandom_range(7) != 0);
      RST  = ($urandom_range(299) == 0);
    end
    @(negedge CLK);
    #2;
    RST  = 1'b0;
    CE_R = 1'b1;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
